debug_register_access: RTL and testbench

//  Byte-serial debug port that initiates register-file reads and writes for an external host.
//  It sits between the chip's byte link (cmd/rsp valid-ready streams) and the core's register-file ports.
//  It stalls the core around each access.
//  The core-side mux gives this block the register-file ports while stall_request && stall_ack.

---
 rtl/debug_register_access_if.sv | 37 +++
 rtl/debug_register_access.sv | 171 +++++++++++++++++
 tb/tb_debug_register_access.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_register_access_if.sv
// Purpose: groups the debug port's host byte streams and core register-file signals.
// Latency: none. This is wiring only.
// Backpressure: cmd and rsp use valid/ready handshakes. The stall_request/stall_ack pair gates register-file ownership.
// Ports (slave view = this block):
//   cmd_valid/cmd_ready/cmd_data : host command byte stream into the block
//   rsp_valid/rsp_ready/rsp_data : response byte stream back to the host
//   stall_request/stall_ack      : core freeze handshake
//   rf_*                         : register-file write port and combinational read port
interface debug_register_access_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        stall_request;
    logic        stall_ack;
    logic        rf_write_enable;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_write_data;
    logic [4:0]  rf_read_address;
    logic [31:0] rf_read_data;

    // The debug block itself.
    modport slave (
        input  cmd_valid, cmd_data, rsp_ready, stall_ack, rf_read_data,
        output cmd_ready, rsp_valid, rsp_data, stall_request,
               rf_write_enable, rf_write_address, rf_write_data, rf_read_address
    );

    // The host/core side that drives the block.
    modport master (
        output cmd_valid, cmd_data, rsp_ready, stall_ack, rf_read_data,
        input  cmd_ready, rsp_valid, rsp_data, stall_request,
               rf_write_enable, rf_write_address, rf_write_data, rf_read_address
    );
endinterface

// File: rtl/debug_register_access.sv
// Purpose: byte-serial debug port. It stalls the core and then performs one register-file read or write per command.
// Latency: for a read with stall_ack already high, the opcode is accepted in cycle 0 and rsp_valid rises in cycle 3.
// Backpressure: cmd_ready is low outside IDLE/GET_DATA. Each response byte is held until rsp_ready takes it.
// Ports:
//   clock   : single clock, posedge
//   reset_n : synchronous active-low reset
//   bus     : debug_register_access_if.slave (cmd/rsp streams, stall handshake, register-file ports)
module debug_register_access #(
    parameter logic [7:0]  ACK_BYTE       = 8'hA5,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clock,
    input  logic                     reset_n,
    debug_register_access_if.slave   bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_DATA = 3'd1,
        STALL    = 3'd2,
        ACCESS   = 3'd3,
        SEND     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    addr_q, addr_d;
    logic          is_write_q, is_write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0]   rsp_sh_q, rsp_sh_d;
    // Number of response bytes still to go after the one currently on rsp_data.
    logic [1:0]    rsp_left_q, rsp_left_d;

    logic          cmd_ready_w;
    logic          rsp_valid_w;
    logic          cmd_acc;
    logic          rsp_acc;
    logic [TW-1:0] tmo_inc;

    // cmd_ready is also gated by reset, so every output reads 0 while reset_n is low.
    assign cmd_ready_w = reset_n && ((state_q == IDLE) || (state_q == GET_DATA));
    assign rsp_valid_w = (state_q == SEND);
    assign cmd_acc     = bus.cmd_valid && cmd_ready_w;
    assign rsp_acc     = rsp_valid_w && bus.rsp_ready;
    assign tmo_inc     = tmo_cnt_q + TW'(1);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            is_write_q <= 1'b0;
            wdata_q    <= '0;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            rsp_sh_q   <= '0;
            rsp_left_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            is_write_q <= is_write_d;
            wdata_q    <= wdata_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rsp_sh_q   <= rsp_sh_d;
            rsp_left_q <= rsp_left_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        is_write_d = is_write_q;
        wdata_d    = wdata_q;
        byte_cnt_d = byte_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        rsp_sh_d   = rsp_sh_q;
        rsp_left_d = rsp_left_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    addr_d     = bus.cmd_data[4:0];
                    is_write_d = bus.cmd_data[7];
                    tmo_cnt_d  = '0;
                    if (bus.cmd_data[6:5] != 2'b00) begin
                        // Malformed opcode: reply with the error byte and never touch the core.
                        rsp_sh_d   = {24'd0, ERR_BYTE};
                        rsp_left_d = 2'd0;
                        state_d    = SEND;
                    end else if (bus.cmd_data[7]) begin
                        byte_cnt_d = 2'd0;
                        state_d    = GET_DATA;
                    end else begin
                        state_d    = STALL;
                    end
                end
            end

            GET_DATA: begin
                if (cmd_acc) begin
                    // Bytes arrive LSB first. Shift each new byte in from the top.
                    // After four bytes, the first byte sits in [7:0].
                    wdata_d    = {bus.cmd_data, wdata_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = STALL;
                    end
                end
            end

            STALL: begin
                if (bus.stall_ack) begin
                    tmo_cnt_d = '0;
                    state_d   = ACCESS;
                end else if (tmo_inc == TW'(TIMEOUT_CYCLES)) begin
                    // stall_request has been high for TIMEOUT_CYCLES cycles without an ack.
                    tmo_cnt_d  = '0;
                    rsp_sh_d   = {24'd0, ERR_BYTE};
                    rsp_left_d = 2'd0;
                    state_d    = SEND;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end

            ACCESS: begin
                // Single-cycle access. stall_ack is not looked at here, so a late drop cannot abort it.
                if (is_write_q) begin
                    rsp_sh_d   = {24'd0, ACK_BYTE};
                    rsp_left_d = 2'd0;
                end else begin
                    rsp_sh_d   = bus.rf_read_data;
                    rsp_left_d = 2'd3;
                end
                state_d = SEND;
            end

            SEND: begin
                if (rsp_acc) begin
                    if (rsp_left_q == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        rsp_sh_d   = {8'd0, rsp_sh_q[31:8]};
                        rsp_left_d = rsp_left_q - 2'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs.
    assign bus.cmd_ready        = cmd_ready_w;
    assign bus.rsp_valid        = rsp_valid_w;
    assign bus.rsp_data         = rsp_valid_w ? rsp_sh_q[7:0] : 8'd0;
    assign bus.stall_request    = (state_q == STALL) || (state_q == ACCESS);
    assign bus.rf_write_enable  = (state_q == ACCESS) && is_write_q && (addr_q != 5'd0);
    assign bus.rf_write_address = addr_q;
    assign bus.rf_write_data    = wdata_q;
    assign bus.rf_read_address  = addr_q;

endmodule

// File: tb/tb_debug_register_access.sv
// Purpose: directed bench for debug_register_access. Expected response bytes go through a scoreboard queue.
// Latency: not applicable.
// Backpressure: the bench drives both cmd_valid and rsp_ready, including deliberate rsp_ready stalls.
module tb_debug_register_access;

    logic clock;
    logic reset_n;
    logic [31:0] read_val;

    debug_register_access_if bus();

    debug_register_access #(
        .ACK_BYTE       (8'hA5),
        .ERR_BYTE       (8'hEE),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Core register-file read model: x0 reads 0, and every other register returns read_val.
    assign bus.rf_read_data = (bus.rf_read_address == 5'd0) ? 32'd0 : read_val;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    // Side-band monitor sampled on the falling edge.
    int          we_cnt      = 0;
    int          we_x0_cnt   = 0;
    int          stall_cyc   = 0;
    logic [4:0]  last_waddr  = 5'd0;
    logic [31:0] last_wdata  = 32'd0;

    always @(negedge clock) begin
        if (bus.rf_write_enable === 1'b1) begin
            we_cnt     <= we_cnt + 1;
            last_waddr <= bus.rf_write_address;
            last_wdata <= bus.rf_write_data;
            if (bus.rf_write_address == 5'd0) we_x0_cnt <= we_x0_cnt + 1;
        end
        if (bus.stall_request === 1'b1) stall_cyc <= stall_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = b;
        while (bus.cmd_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) check("cmd_ready_timeout", 32'd0, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'd0;
    endtask

    // Take n response bytes with rsp_ready high, comparing each against the scoreboard.
    task automatic recv_bytes(input int n, input string tag);
        int w;
        logic [7:0] e;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (bus.rsp_valid !== 1'b1 && w < 100) begin
                tick();
                w++;
            end
            check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_rsp_data"}, {24'd0, bus.rsp_data}, {24'd0, e});
            end else begin
                check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            end
            tick();
        end
    endtask

    int we0, st0, lat;

    initial begin
        reset_n       = 1'b0;
        read_val      = 32'd0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'd0;
        bus.rsp_ready = 1'b0;
        bus.stall_ack = 1'b1;
        tick();
        tick();

        // Reset state.
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_stall_req", {31'd0, bus.stall_request}, 32'd0);
        check("rst_rf_we", {31'd0, bus.rf_write_enable}, 32'd0);
        check("rst_waddr", {27'd0, bus.rf_write_address}, 32'd0);
        check("rst_wdata", bus.rf_write_data, 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // 1. Write x5 = 0x12345678.
        we0 = we_cnt;
        exp_q.push_back(8'hA5);
        send_byte(8'h85);
        check("wr5_waddr_latched", {27'd0, bus.rf_write_address}, 32'd5);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        recv_bytes(1, "wr5");
        check("wr5_rsp_done", {31'd0, bus.rsp_valid}, 32'd0);
        check("wr5_we_pulses", we_cnt - we0, 32'd1);
        check("wr5_we_addr", {27'd0, last_waddr}, 32'd5);
        check("wr5_we_data", last_wdata, 32'h12345678);

        // 2. Read x5 with a latency check, and rsp_ready held low for 3 cycles mid-response.
        read_val = 32'hDEADBEEF;
        st0 = stall_cyc;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'hDE);
        bus.rsp_ready = 1'b0;
        send_byte(8'h05);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        check("rd5_latency", lat, 32'd3);
        recv_bytes(1, "rd5_b0");
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("rd5_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("rd5_hold_data", {24'd0, bus.rsp_data}, {24'd0, exp_q[0]});
            tick();
        end
        recv_bytes(3, "rd5_rest");
        check("rd5_rsp_done", {31'd0, bus.rsp_valid}, 32'd0);
        check("rd5_stall_cycles", stall_cyc - st0, 32'd2);
        check("rd5_scoreboard_drained", exp_q.size(), 32'd0);

        // 3. A write to x0 is suppressed but still ACKed. A read of x0 returns zeros.
        we0 = we_cnt;
        exp_q.push_back(8'hA5);
        send_byte(8'h80);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        recv_bytes(1, "wr0");
        check("wr0_no_we", we_cnt - we0, 32'd0);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h00);
        send_byte(8'h00);
        recv_bytes(4, "rd0");

        // 4. A reserved opcode bit gives an error byte with no stall.
        st0 = stall_cyc;
        exp_q.push_back(8'hEE);
        send_byte(8'h25);
        recv_bytes(1, "rsvd");
        check("rsvd_no_stall", stall_cyc - st0, 32'd0);

        // 5. Stall timeout with TIMEOUT_CYCLES=4.
        bus.stall_ack = 1'b0;
        st0 = stall_cyc;
        we0 = we_cnt;
        exp_q.push_back(8'hEE);
        send_byte(8'h83);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        recv_bytes(1, "tmo");
        check("tmo_stall_cycles", stall_cyc - st0, 32'd4);
        check("tmo_no_we", we_cnt - we0, 32'd0);
        check("tmo_stall_dropped", {31'd0, bus.stall_request}, 32'd0);
        bus.stall_ack = 1'b1;

        // 6. A reset in the middle of GET_DATA aborts the command.
        we0 = we_cnt;
        st0 = stall_cyc;
        send_byte(8'h87);
        send_byte(8'h01);
        send_byte(8'h02);
        reset_n = 1'b0;
        tick();
        check("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_mid_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        reset_n = 1'b1;
        tick();
        check("rst_mid_idle", {31'd0, bus.cmd_ready}, 32'd1);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        check("rst_mid_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_mid_no_we", we_cnt - we0, 32'd0);
        check("rst_mid_no_stall", stall_cyc - st0, 32'd0);

        // After the reset, a fresh read still works.
        read_val = 32'h0BADF00D;
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'h0B);
        send_byte(8'h07);
        recv_bytes(4, "rd7");

        check("never_we_x0", we_x0_cnt, 32'd0);
        check("final_scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
